spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
//   SPI mode-0 initiator: drives nCS/SCLK/COPI to program the onboarding SPI register
//   peripheral (enables, PWM enables, duty cycle) from on-chip logic or a test harness.
//   Takes one register write (or read-capture) request per handshake and serialises a
//   16-bit frame MSB first: {rw, addr[6:0], data[7:0]}. Sits beside the top level;
//   its sclk/ncs/copi pins wire straight to the peripheral's SCLK/nCS/COPI pins.
// PARAMETERS
//   CLK_DIV     4  clk cycles per SCLK half-period; must be >=3 (peripheral 2-FF syncs SCLK)
//   GAP_CYCLES  4  clk cycles nCS stays high after a frame before the next is accepted
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  async active-low reset
//   req_valid  in   1  request present
//   req_ready  out  1  high only in IDLE; transfer accepted when req_valid & req_ready
//   req_write  in   1  frame bit 15 (1 = write)
//   req_addr   in   7  frame bits 14:8
//   req_wdata  in   8  frame bits 7:0
//   rsp_done   out  1  one-cycle pulse at frame end
//   rsp_rdata  out  8  last 8 CIPO bits of the frame; valid from rsp_done, held until next done
//   busy       out  1  high from acceptance until req_ready returns
//   sclk       out  1  SPI clock, idle low
//   ncs        out  1  chip select, active low
//   copi       out  1  serial data to peripheral
//   cipo       in   1  serial data from peripheral (tie 0 if unused)
// BEHAVIOUR
//   Reset values: req_ready=1, busy=0, rsp_done=0, rsp_rdata=0, sclk=0, ncs=1, copi=0;
//     reset asserted mid-frame forces these immediately (async); the frame is dropped.
//   States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   Accept on edge T (IDLE, req_valid): latch frame; inputs ignored afterwards. From T:
//     SETUP ncs=0, copi=frame[15]; sclk rises at T+CLK_DIV.
//   SHIFT: sclk toggles every CLK_DIV cycles; rising k at T+(2k-1)*CLK_DIV, k=1..16.
//     cipo sampled into rx shift reg on each rising edge. On each falling edge except
//     the 16th, copi advances to next bit. 16th fall at T+32*CLK_DIV -> HOLD, sclk=0.
//   HOLD: CLK_DIV cycles; then ncs=1 and rsp_done=1 both at T+33*CLK_DIV;
//     rsp_rdata <= rx[7:0] same edge; copi=0.
//   GAP: GAP_CYCLES cycles; req_ready=1, busy=0 at T+33*CLK_DIV+GAP_CYCLES.
//     Defaults: ncs high at T+132, ready at T+136.
//   req_valid while !req_ready: ignored, no queueing. GAP_CYCLES=0: IDLE straight after HOLD.
//   Bit counter 4 bits, divider counter $clog2(CLK_DIV) bits, both wrap-free (reset per phase).
//   Address not range-checked; frame sent verbatim. CLK_DIV<3: $error at elaboration.
//   sclk, ncs, copi driven directly from flops (glitch-free).
// STRUCTURE
//   Package spi_pkg: FRAME_W=16, ADDR_W=7, DATA_W=8, state enum, register address
//     constants (REG_EN_OUT_7_0=0x00, REG_EN_OUT_15_8=0x01, REG_EN_PWM_7_0=0x02,
//     REG_EN_PWM_15_8=0x03, REG_PWM_DUTY=0x04), shared with the peripheral and bench.
//   Sub-module spi_sclk_divider: counts CLK_DIV, emits one-cycle rise/fall strobes
//     while enabled; FSM plus shift registers stay in this module.
// TESTING
//   1 Reset: check all outputs at reset values; ready=1.
//   2 Write 0x04 <- 0x80: COPI on 16 rising edges = 0x8480 MSB first; ncs low exactly
//     32*CLK_DIV+CLK_DIV cycles; one rsp_done; peripheral pwm_duty_cycle reads 0x80.
//   3 Timing: CLK_DIV=4, GAP=4: rise 1 at T+4, fall 16 at T+128, ncs high and done
//     at T+132, ready at T+136.
//   4 Back-to-back: req_valid held with 0x00<-0xFF then 0x02<-0x01; second accepted
//     only at ready; both registers updated; ncs high >= GAP_CYCLES between frames.
//   5 Read capture: cipo model returns 0xA5 in last 8 bits -> rsp_rdata=0xA5 at rsp_done;
//     req_valid pulses mid-frame change nothing.
//   6 Reset mid-frame at bit 7: ncs=1, sclk=0 same cycle; peripheral registers unchanged;
//     after release, a fresh write 0x01<-0x3C completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI frame layout, FSM encodings and peripheral register map.
package spi_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETUP = 3'd1;
    localparam logic [STATE_W-1:0] ST_SHIFT = 3'd2;
    localparam logic [STATE_W-1:0] ST_HOLD  = 3'd3;
    localparam logic [STATE_W-1:0] ST_GAP   = 3'd4;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    function automatic spi_frame_t make_frame(input logic rw,
                                              input logic [ADDR_W-1:0] addr,
                                              input logic [DATA_W-1:0] data);
        spi_frame_t f;
        f.rw   = rw;
        f.addr = addr;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// SCLK timebase: one-cycle rise/fall strobes every CLK_DIV clocks while enabled.
module spi_sclk_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;
    logic             tick;

    assign tick   = en && (cnt_q == CNT_LAST);
    assign rise_c = tick && !phase_q;
    assign fall_c = tick && phase_q;

    // Counter and phase restart whenever the divider is idle so each frame starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= !phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one 16-bit {rw, addr, data} frame per request.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              ncs,
    output logic              copi,
    input  logic              cipo
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    if (CLK_DIV < 3) begin : g_clk_div_check
        $error("spi_controller: CLK_DIV must be >= 3");
    end

    logic [STATE_W-1:0] state_q, state_d;
    logic [FRAME_W-2:0] tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               sclk_q, sclk_d;
    logic               ncs_q, ncs_d;
    logic               copi_q, copi_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               div_en;
    logic               rise_c;
    logic               fall_c;
    spi_frame_t         frame_c;

    assign div_en  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign frame_c = make_frame(req_write, req_addr, req_wdata);

    spi_sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (div_en),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Frame sequencing; every pin and status output is computed here and registered below.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        ncs_d     = ncs_q;
        copi_d    = copi_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d   = ST_SETUP;
                    tx_d      = frame_c[FRAME_W-2:0];
                    copi_d    = frame_c[FRAME_W-1];
                    ncs_d     = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (rise_c) begin
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[DATA_W-2:0], cipo};
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_c) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[DATA_W-2:0], cipo};
                end else if (fall_c) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d = 4'(bit_cnt_q + 4'd1);
                        copi_d    = tx_q[FRAME_W-2];
                        tx_d      = {tx_q[FRAME_W-3:0], 1'b0};
                    end
                end
            end
            // The divider's next rise strobe marks the end of the CLK_DIV hold time.
            ST_HOLD: begin
                if (rise_c) begin
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = rx_q;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = GAP_W'(gap_cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                ncs_d   = 1'b1;
                copi_d  = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            copi_q    <= copi_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_done  = done_q;
    assign rsp_rdata = rdata_q;
    assign sclk      = sclk_q;
    assign ncs       = ncs_q;
    assign copi      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Randomized bench for spi_controller with a pin-level peripheral model and timing reference.
module tb_spi_controller;
    import spi_pkg::*;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned GAP_CYCLES = 4;
    localparam int          FRAME_CYC  = 33 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       cipo = 1'b0;
    logic       req_ready, rsp_done, busy, sclk, ncs, copi;
    logic [7:0] rsp_rdata;

    spi_controller #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_done  (rsp_done),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .cipo      (cipo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pin-level peripheral: shifts COPI on SCLK rise, drives CIPO on falls, commits on nCS rise.
    logic        prev_sclk = 1'b0, prev_ncs = 1'b1, prev_ready = 1'b1;
    int          bit_n = 0, frames = 0, done_cnt = 0;
    int          ncs_fall_cyc = -1, ncs_rise_cyc = -1, first_rise_cyc = -1;
    int          last_fall_cyc = -1, done_cyc = -1, ready_cyc = -1;
    logic [15:0] shift_in = '0, last_frame = '0, cipo_word = '0;
    logic [7:0]  done_rdata = '0;
    logic [7:0]  peri_regs [5];
    logic [7:0]  exp_regs [5];

    always @(negedge clk) begin
        if (prev_ncs === 1'b1 && ncs === 1'b0) begin
            ncs_fall_cyc = cyc;
            bit_n        = 0;
            cipo         = cipo_word[15];
        end
        if (ncs === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) begin
            if (bit_n == 0) first_rise_cyc = cyc;
            shift_in = {shift_in[14:0], copi};
            bit_n++;
        end
        if (prev_sclk === 1'b1 && sclk === 1'b0) begin
            last_fall_cyc = cyc;
            if (bit_n < 16) cipo = cipo_word[15-bit_n];
        end
        if (prev_ncs === 1'b0 && ncs === 1'b1) begin
            ncs_rise_cyc = cyc;
            if (bit_n == 16) begin
                last_frame = shift_in;
                frames++;
                if (shift_in[15] && int'(shift_in[14:8]) < 5)
                    peri_regs[int'(shift_in[14:8])] = shift_in[7:0];
            end
            bit_n = 0;
            cipo  = 1'b0;
        end
        if (rsp_done === 1'b1) begin
            done_cnt++;
            done_cyc   = cyc;
            done_rdata = rsp_rdata;
        end
        if (prev_ready === 1'b0 && req_ready === 1'b1) ready_cyc = cyc;
        prev_sclk  = sclk;
        prev_ncs   = ncs;
        prev_ready = req_ready;
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic [15:0] cw, output int t);
        cipo_word = cw;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 2000 && !req_ready; i++) tick();
        check_eq("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    task automatic finish_frame(input int t, input logic [15:0] exp_frame, input logic [15:0] cw,
                                input bit glitch, input bit keep_valid);
        int d0;
        int a;
        d0 = done_cnt;
        if (!keep_valid) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = 7'($urandom);
            req_wdata = 8'($urandom);
        end
        for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
            tick();
            if (glitch && done_cnt == d0) begin
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'($urandom);
                req_addr  = 7'($urandom);
                req_wdata = 8'($urandom);
            end
        end
        if (!keep_valid) req_valid = 1'b0;
        check_eq("done_pulse", 32'(done_cnt - d0), 32'd1);
        check_eq("done_time", 32'(done_cyc), 32'(t + FRAME_CYC));
        check_eq("ncs_fall_time", 32'(ncs_fall_cyc), 32'(t));
        check_eq("first_rise_time", 32'(first_rise_cyc), 32'(t + CLK_DIV));
        check_eq("last_fall_time", 32'(last_fall_cyc), 32'(t + 32 * CLK_DIV));
        check_eq("ncs_rise_time", 32'(ncs_rise_cyc), 32'(t + FRAME_CYC));
        check_eq("frame_bits", 32'(last_frame), 32'(exp_frame));
        check_eq("rdata_at_done", 32'(done_rdata), 32'(cw[7:0]));
        for (int i = 0; i < 200 && !req_ready; i++) tick();
        check_eq("ready_time", 32'(ready_cyc), 32'(t + FRAME_CYC + int'(GAP_CYCLES)));
        check_eq("rdata_held", 32'(rsp_rdata), 32'(cw[7:0]));
        check_eq("busy_after", 32'(busy), 32'd0);
        a = int'(exp_frame[14:8]);
        if (exp_frame[15] && a < 5) exp_regs[a] = exp_frame[7:0];
        for (int r = 0; r < 5; r++) check_eq($sformatf("reg%0d", r), 32'(peri_regs[r]), 32'(exp_regs[r]));
    endtask

    task automatic run_frame(input logic w, input logic [6:0] a, input logic [7:0] d,
                             input logic [15:0] cw, input bit glitch);
        int t;
        issue(w, a, d, cw, t);
        finish_frame(t, {w, a, d}, cw, glitch, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, f0;
        logic [15:0] cw, cw2;
        logic [6:0]  ra;
        logic [7:0]  rd;
        logic        rw;
        for (int r = 0; r < 5; r++) begin
            peri_regs[r] = '0;
            exp_regs[r]  = '0;
        end

        // Reset values
        repeat (3) tick();
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(rsp_done), 32'd0);
        check_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_ncs", 32'(ncs), 32'd1);
        check_eq("rst_copi", 32'(copi), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Duty-cycle write: frame 0x8480, ncs low 33*CLK_DIV cycles
        cw = 16'($urandom);
        issue(1'b1, REG_PWM_DUTY, 8'h80, cw, t1);
        check_eq("busy_on_accept", 32'(busy), 32'd1);
        finish_frame(t1, 16'h8480, cw, 1'b0, 1'b0);
        check_eq("ncs_low_width", 32'(ncs_rise_cyc - ncs_fall_cyc), 32'(FRAME_CYC));
        check_eq("pwm_duty", 32'(peri_regs[4]), 32'h80);

        // Back-to-back with req_valid held
        tick();
        cw  = 16'($urandom);
        cw2 = 16'($urandom);
        issue(1'b1, REG_EN_OUT_7_0, 8'hFF, cw, t1);
        req_write = 1'b1;
        req_addr  = REG_EN_PWM_7_0;
        req_wdata = 8'h01;
        finish_frame(t1, 16'h80FF, cw, 1'b0, 1'b1);
        issue(1'b1, REG_EN_PWM_7_0, 8'h01, cw2, t2);
        check_eq("b2b_accept_time", 32'(t2), 32'(t1 + FRAME_CYC + int'(GAP_CYCLES) + 1));
        check_eq("b2b_gap_ok", 32'((t2 - (t1 + FRAME_CYC)) >= int'(GAP_CYCLES)), 32'd1);
        finish_frame(t2, 16'h8201, cw2, 1'b0, 1'b0);

        // Read capture with CIPO low byte 0xA5 and req_valid noise mid-frame
        tick();
        run_frame(1'b0, REG_PWM_DUTY, 8'h00, {8'($urandom), 8'hA5}, 1'b1);

        // Randomized frames
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 5)) tick();
            rw = 1'($urandom);
            ra = 7'($urandom_range(0, 7));
            rd = 8'($urandom);
            run_frame(rw, ra, rd, 16'($urandom), 1'($urandom));
        end

        // Reset mid-frame at bit 7
        tick();
        f0 = frames;
        issue(1'b1, REG_EN_PWM_7_0, 8'h77, 16'($urandom), t1);
        req_valid = 1'b0;
        for (int i = 0; i < 2000 && bit_n < 7; i++) tick();
        check_eq("reached_bit7", 32'(bit_n), 32'd7);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_ncs", 32'(ncs), 32'd1);
        check_eq("mrst_sclk", 32'(sclk), 32'd0);
        check_eq("mrst_copi", 32'(copi), 32'd0);
        check_eq("mrst_ready", 32'(req_ready), 32'd1);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_rdata", 32'(rsp_rdata), 32'd0);
        repeat (3) tick();
        check_eq("mrst_frames", 32'(frames), 32'(f0));
        check_eq("mrst_reg2", 32'(peri_regs[2]), 32'(exp_regs[2]));
        rst_n = 1'b1;
        repeat (2) tick();
        run_frame(1'b1, REG_EN_OUT_15_8, 8'h3C, 16'($urandom), 1'b0);
        check_eq("fresh_reg1", 32'(peri_regs[1]), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
